// File: rtl/modulo_entrada.sv
// Input conditioning for the processor: synchronises the push-button and slide switches
// to clk, debounces the button and emits one enter pulse with the captured switch word.
module modulo_entrada #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DATA_W          = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_n,
  input  logic [DATA_W-1:0] sw,
  output logic              enter,
  output logic [DATA_W-1:0] dados,
  output logic              pressionado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_t;

  logic              k1_q, k2_q;
  logic [DATA_W-1:0] s1_q, s2_q;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic              enter_q, enter_d;
  logic [DATA_W-1:0] dados_q, dados_d;

  // Two-flop synchronisers; the key idles released so reset looks like "not pressed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k1_q <= 1'b1;
      k2_q <= 1'b1;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      k1_q <= key_n;
      k2_q <= k1_q;
      s1_q <= sw;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      enter_q <= 1'b0;
      dados_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enter_q <= enter_d;
      dados_q <= dados_d;
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter_d = 1'b0;
    dados_d = dados_q;
    unique case (state_q)
      IDLE: begin
        if (!k2_q) begin
          state_d = ARMING;
          cnt_d   = CNT_ONE;
        end
      end
      ARMING: begin
        if (k2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          enter_d = 1'b1;
          dados_d = s2_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (k2_q) begin
          state_d = RELEASING;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASING: begin
        // A low sample here is release bounce: back to PRESSED without a new pulse.
        if (!k2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    enter       = enter_q;
    dados       = dados_q;
    pressionado = (state_q == PRESSED) || (state_q == RELEASING);
  end

endmodule
